// File: rtl/tlb_refill_ctrl.sv
// TLB refill engine: fetches one PTE on a miss and writes the CAM tag and PFN RAM
// at a round-robin victim index. Define TLB_WIRED_EN to add locked low entries.
module tlb_refill_ctrl #(
  parameter int VPN_W = 20,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             clrn,
`ifdef TLB_WIRED_EN
  input  logic [IDX_W-1:0] wired,
`endif
  input  logic             miss,
  input  logic [VPN_W-1:0] miss_vpn,
  input  logic [31:0]      ptbase,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             cam_wren,
  output logic [VPN_W-1:0] cam_pattern,
  output logic [IDX_W-1:0] cam_wraddress,
  output logic             ram_wren,
  output logic [23:0]      ram_data,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [VPN_W-1:0] vpn_r;
  logic [31:0]      pte_r;
  logic [IDX_W-1:0] vptr;
  logic [IDX_W-1:0] victim;
  logic [IDX_W-1:0] victim_nxt;
  logic [IDX_W-1:0] wrap_idx;
  logic [31:0]      pte_addr;

  // Word-indexed PTE address; the carry out of bit 31 is discarded.
  assign pte_addr = ptbase + 32'({miss_vpn, 2'b00});

`ifdef TLB_WIRED_EN
  // A pointer left below the wired boundary is bumped up to the first unlocked entry.
  assign victim   = (vptr < wired) ? wired : vptr;
  assign wrap_idx = wired;
`else
  assign victim   = vptr;
  assign wrap_idx = '0;
`endif

  assign victim_nxt = (victim == IDX_LAST) ? wrap_idx : victim + IDX_ONE;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the processes are evaluated in.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vpn_r    <= '0;
      mem_addr <= '0;
      pte_r    <= '0;
      vptr     <= '0;
    end else begin
      if (state == S_IDLE && miss) begin
        vpn_r    <= miss_vpn;
        mem_addr <= pte_addr;
      end
      if (state == S_REQ && mem_ack) begin
        pte_r <= mem_rdata;
      end
      if (state == S_WRITE) begin
        vptr <= victim_nxt;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    mem_req       = 1'b0;
    cam_wren      = 1'b0;
    ram_wren      = 1'b0;
    cam_pattern   = '0;
    cam_wraddress = '0;
    ram_data      = '0;
    busy          = 1'b1;
    done          = 1'b0;
    fault         = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (miss) state_nxt = S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = mem_rdata[0] ? S_WRITE : S_FAULT;
      end
      S_WRITE: begin
        cam_wren      = 1'b1;
        ram_wren      = 1'b1;
        cam_pattern   = vpn_r;
        cam_wraddress = victim;
        ram_data      = {pte_r[31:12], pte_r[3:0]};
        state_nxt     = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAULT: begin
        fault     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Self-checking bench for tlb_refill_ctrl: table of refills plus hand-built corner
// sequences; a scoreboard queue holds the expected CAM/RAM writes and faults.
module tb_tlb_refill_ctrl;

  localparam int VPN_W = 20;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic             miss = 1'b0;
  logic [VPN_W-1:0] miss_vpn = '0;
  logic [31:0]      ptbase = '0;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_rdata = '0;
  logic [IDX_W-1:0] wired = '0;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             cam_wren;
  logic [VPN_W-1:0] cam_pattern;
  logic [IDX_W-1:0] cam_wraddress;
  logic             ram_wren;
  logic [23:0]      ram_data;
  logic             busy;
  logic             done;
  logic             fault;

  tlb_refill_ctrl #(.VPN_W(VPN_W), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .clrn          (clrn),
`ifdef TLB_WIRED_EN
    .wired         (wired),
`endif
    .miss          (miss),
    .miss_vpn      (miss_vpn),
    .ptbase        (ptbase),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .cam_wren      (cam_wren),
    .cam_pattern   (cam_pattern),
    .cam_wraddress (cam_wraddress),
    .ram_wren      (ram_wren),
    .ram_data      (ram_data),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VPN_W-1:0] pattern;
    logic [IDX_W-1:0] idx;
    logic [23:0]      data;
    logic             is_fault;
  } exp_t;

  typedef struct {
    logic [VPN_W-1:0] vpn;
    logic [31:0]      base;
    logic [31:0]      rdata;
    int               delay;
    logic [31:0]      addr;
  } vec_t;

  exp_t             sb[$];
  exp_t             mon_e;
  vec_t             vecs[4];
  int               n_checks = 0;
  int               n_fail = 0;
  int               n_done = 0;
  int               n_fault = 0;
  int               exp_done = 0;
  int               exp_fault = 0;
  logic [IDX_W-1:0] exp_ptr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write or fault pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clrn) begin
      if (done)  n_done++;
      if (fault) n_fault++;
      if (cam_wren || ram_wren || fault) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: wren=%b/%b fault=%b with empty scoreboard at %0t",
                   cam_wren, ram_wren, fault, $time);
        end else begin
          mon_e = sb.pop_front();
          check("fault_kind", 32'(fault), 32'(mon_e.is_fault));
          check("wren_pair", 32'({cam_wren, ram_wren}), mon_e.is_fault ? 32'd0 : 32'd3);
          if (!mon_e.is_fault) begin
            check("cam_pattern", 32'(cam_pattern), 32'(mon_e.pattern));
            check("cam_wraddress", 32'(cam_wraddress), 32'(mon_e.idx));
            check("ram_data", 32'(ram_data), 32'(mon_e.data));
          end
        end
      end
    end
  end

  // One complete refill: miss -> REQ (delay extra cycles) -> ack -> WRITE/DONE or FAULT -> IDLE.
  task automatic refill(input logic [VPN_W-1:0] vpn, input logic [31:0] base,
                        input logic [31:0] rdata, input int delay,
                        input logic [31:0] exp_addr, input bit glitch);
    exp_t             e;
    logic [IDX_W-1:0] idx;
    idx        = (exp_ptr < wired) ? wired : exp_ptr;
    e.pattern  = vpn;
    e.data     = {rdata[31:12], rdata[3:0]};
    e.is_fault = ~rdata[0];
    e.idx      = idx;
    if (rdata[0]) begin
      exp_ptr = (idx == {IDX_W{1'b1}}) ? wired : idx + 1'b1;
      exp_done++;
    end else begin
      exp_fault++;
    end
    sb.push_back(e);

    @(negedge clk);
    miss = 1'b1; miss_vpn = vpn; ptbase = base;
    @(negedge clk);
    miss = 1'b0; miss_vpn = VPN_W'($urandom); ptbase = $urandom;
    check("req_after_miss", 32'(mem_req), 32'd1);
    check("busy_req", 32'(busy), 32'd1);
    check("mem_addr", mem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      if (glitch && i == 0) begin
        miss = 1'b1; miss_vpn = 20'h00111;
      end else begin
        miss = 1'b0;
      end
      @(negedge clk);
      check("req_held", 32'(mem_req), 32'd1);
      check("addr_held", mem_addr, exp_addr);
    end
    miss = 1'b0;
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    check("req_drop", 32'(mem_req), 32'd0);
    if (rdata[0]) begin
      check("write_cycle", 32'(cam_wren), 32'd1);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("wren_off", 32'({cam_wren, ram_wren}), 32'd0);
    end else begin
      check("fault_pulse", 32'(fault), 32'd1);
      check("fault_no_wren", 32'({cam_wren, ram_wren}), 32'd0);
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("pulse_clear", 32'({done, fault}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{20'h00ABC, 32'h0010_0000, 32'h1234_5000, 1, 32'h0010_2AF0};
    vecs[1] = '{20'h00ABC, 32'h0010_0000, 32'h1234_500B, 3, 32'h0010_2AF0};
    vecs[2] = '{20'h00001, 32'h8000_0000, 32'hFFFF_F00F, 0, 32'h8000_0004};
    vecs[3] = '{20'hFFFFF, 32'hFFFF_FFF0, 32'hABCD_E00D, 2, 32'h003F_FFEC};

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_outs", 32'({cam_wren, ram_wren, done, fault}), 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Fault first, so the following valid refill must still land at index 0.
    foreach (vecs[i]) refill(vecs[i].vpn, vecs[i].base, vecs[i].rdata, vecs[i].delay, vecs[i].addr, 1'b0);

    // Nine more valid refills walk the pointer across the wrap boundary.
    for (int i = 0; i < 9; i++) begin
      logic [VPN_W-1:0] v;
      v = VPN_W'(32'h100 + i);
      refill(v, 32'h0, {12'h5A5, 8'(i), 12'h003}, i % 3, {10'h0, v, 2'b00}, 1'b0);
    end

    // A miss during REQ is dropped; only the scoreboarded write may appear.
    refill(20'h00222, 32'h0000_1000, 32'h0000_1001, 3, 32'h0000_1888, 1'b1);
    check("done_count", 32'(n_done), 32'(exp_done));

    // Asynchronous reset while mem_req is high, then a stale ack.
    @(negedge clk);
    miss = 1'b1; miss_vpn = 20'h00333; ptbase = 32'h0;
    @(negedge clk);
    miss = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 clrn = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_addr", mem_addr, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_F001;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    check("late_ack_ignored", 32'({busy, cam_wren}), 32'd0);
    mem_ack = 1'b0;
    exp_ptr = '0;
    refill(20'h00444, 32'h0, 32'h7777_7003, 1, 32'h0000_1110, 1'b0);

`ifdef TLB_WIRED_EN
    @(negedge clk);
    clrn = 1'b0; wired = 3'd3;
    @(negedge clk);
    clrn = 1'b1; exp_ptr = '0;
    for (int i = 0; i < 6; i++) begin
      logic [VPN_W-1:0] v;
      v = VPN_W'(32'h500 + i);
      refill(v, 32'h0, {12'h0C3, 8'(i), 12'h001}, 1, {10'h0, v, 2'b00}, 1'b0);
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_total", 32'(n_done), 32'(exp_done));
    check("fault_total", 32'(n_fault), 32'(exp_fault));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
